// File: rtl/taxi_axil_pkg.sv
// taxi_axil_pkg
//   Shared definitions for the AXI4-lite register-interface endpoints
//   (taxi_axil_reg_if_wr and its read-side sibling taxi_axil_reg_if_rd).
//   - AXI response encodings
//   - endpoint FSM state type
package taxi_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } axil_reg_state_t;

endpackage

// File: rtl/taxi_axil_if.sv
// taxi_axil_if
//   AXI4-lite write-channel bundle (AW, W, B).
//   Parameters: DATA_W, ADDR_W, STRB_W, AWUSER_W, WUSER_W, BUSER_W.
//   Modports: wr_mst (drives AW/W, accepts B), wr_slv (the reverse).
interface taxi_axil_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int STRB_W   = DATA_W / 8,
  parameter int AWUSER_W = 1,
  parameter int WUSER_W  = 1,
  parameter int BUSER_W  = 1
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic [AWUSER_W-1:0] awuser;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [STRB_W-1:0]   wstrb;
  logic [WUSER_W-1:0]  wuser;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic [BUSER_W-1:0]  buser;
  logic                bvalid;
  logic                bready;

  modport wr_mst (
    output awaddr, awprot, awuser, awvalid, input awready,
    output wdata, wstrb, wuser, wvalid, input wready,
    input bresp, buser, bvalid, output bready
  );

  modport wr_slv (
    input awaddr, awprot, awuser, awvalid, output awready,
    input wdata, wstrb, wuser, wvalid, output wready,
    output bresp, buser, bvalid, input bready
  );

endinterface

// File: rtl/taxi_axil_reg_if_wr.sv
// taxi_axil_reg_if_wr
//   AXI4-lite write endpoint: accepts AW and W (any order), issues one
//   register write strobe held until the target completes, then returns B.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     s_axil_wr      AXI4-lite write slave (widths come from the interface)
//     reg_wr_addr    word-aligned write address
//     reg_wr_data    write data
//     reg_wr_strb    byte strobes
//     reg_wr_en      write request, held while pending
//     reg_wr_wait    target stall (sampled while reg_wr_en=1)
//     reg_wr_ack     target completion (sampled while reg_wr_en=1)
//   Optional: define TAXI_AXIL_REG_IF_WR_TIMEOUT_EN to force completion with
//   SLVERR after TIMEOUT stalled cycles.
module taxi_axil_reg_if_wr
  import taxi_axil_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  taxi_axil_if.wr_slv                   s_axil_wr,
  output logic [s_axil_wr.ADDR_W-1:0]   reg_wr_addr,
  output logic [s_axil_wr.DATA_W-1:0]   reg_wr_data,
  output logic [s_axil_wr.STRB_W-1:0]   reg_wr_strb,
  output logic                          reg_wr_en,
  input  logic                          reg_wr_wait,
  input  logic                          reg_wr_ack
);

  localparam int ADDR_W = s_axil_wr.ADDR_W;
  localparam int DATA_W = s_axil_wr.DATA_W;
  localparam int STRB_W = s_axil_wr.STRB_W;
  // clears the byte-offset bits so the target always sees a word address
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(STRB_W - 1);

  axil_reg_state_t     r_state;
  logic                r_awready, r_wready, r_bvalid, r_en;
  logic                r_aw_cap, r_w_cap;
  logic [1:0]          r_bresp;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [STRB_W-1:0]   r_strb;

`ifdef TAXI_AXIL_REG_IF_WR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    r_cnt;
`endif

  logic w_aw_hs, w_w_hs, w_aw_got, w_w_got;
  assign w_aw_hs  = r_awready && s_axil_wr.awvalid;
  assign w_w_hs   = r_wready && s_axil_wr.wvalid;
  assign w_aw_got = r_aw_cap || w_aw_hs;
  assign w_w_got  = r_w_cap || w_w_hs;

  // prot/user sidebands carry nothing a register bank can use
  logic w_unused;
  assign w_unused = ^{s_axil_wr.awprot, s_axil_wr.awuser, s_axil_wr.wuser, 1'(TIMEOUT > 0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
      r_en      <= 1'b0;
      r_aw_cap  <= 1'b0;
      r_w_cap   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
`ifdef TAXI_AXIL_REG_IF_WR_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) r_addr <= s_axil_wr.awaddr & ADDR_MASK;
          if (w_w_hs) begin
            r_data <= s_axil_wr.wdata;
            r_strb <= s_axil_wr.wstrb;
          end
          r_aw_cap  <= w_aw_got;
          r_w_cap   <= w_w_got;
          // each ready drops once its own beat is held
          r_awready <= !w_aw_got;
          r_wready  <= !w_w_got;
          if (w_aw_got && w_w_got) begin
            r_en    <= 1'b1;
            r_state <= ST_ISSUE;
`ifdef TAXI_AXIL_REG_IF_WR_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          // ack completes even while wait is still asserted, and beats timeout
          if (reg_wr_ack || !reg_wr_wait) begin
            r_en     <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= AXI_RESP_OKAY;
            r_state  <= ST_RESP;
          end
`ifdef TAXI_AXIL_REG_IF_WR_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_en     <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= AXI_RESP_SLVERR;
            r_state  <= ST_RESP;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (s_axil_wr.bready) begin
            r_bvalid  <= 1'b0;
            r_aw_cap  <= 1'b0;
            r_w_cap   <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axil_wr.awready = r_awready;
  assign s_axil_wr.wready  = r_wready;
  assign s_axil_wr.bvalid  = r_bvalid;
  assign s_axil_wr.bresp   = r_bresp;
  assign s_axil_wr.buser   = '0;

  assign reg_wr_addr = r_addr;
  assign reg_wr_data = r_data;
  assign reg_wr_strb = r_strb;
  assign reg_wr_en   = r_en;

endmodule

// File: tb/tb_taxi_axil_reg_if_wr.sv
// tb_taxi_axil_reg_if_wr
//   Directed bench for taxi_axil_reg_if_wr (32-bit data/address).
//   Follows TAXI_AXIL_REG_IF_WR_TIMEOUT_EN when checking stall behaviour.
module tb_taxi_axil_reg_if_wr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] reg_wr_addr;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_en;
  logic        reg_wr_wait = 1'b0;
  logic        reg_wr_ack = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0]  q_strb[$];
  logic [1:0]  q_resp[$];

  taxi_axil_if #(.DATA_W(32), .ADDR_W(32)) axil ();

  taxi_axil_reg_if_wr #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_axil_wr   (axil),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_wait (reg_wr_wait),
    .reg_wr_ack  (reg_wr_ack)
  );

  always #5 clk = ~clk;

  // inputs change at posedge+1, so values seen here are what the next edge samples
  always @(negedge clk) begin
    if (reg_wr_en && (reg_wr_ack || !reg_wr_wait)) begin
      q_addr.push_back(reg_wr_addr);
      q_data.push_back(reg_wr_data);
      q_strb.push_back(reg_wr_strb);
    end
    if (axil.bvalid && axil.bready) q_resp.push_back(axil.bresp);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // presents AW and W together; returns just after the edge that took the last beat
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int  n;
    logic aa, wa;
    n = 0;
    axil.awaddr = a; axil.wdata = d; axil.wstrb = s;
    axil.awvalid = 1'b1; axil.wvalid = 1'b1;
    while ((axil.awvalid || axil.wvalid) && n < 20) begin
      aa = axil.awvalid && axil.awready;
      wa = axil.wvalid && axil.wready;
      step();
      n++;
      if (aa) axil.awvalid = 1'b0;
      if (wa) axil.wvalid = 1'b0;
    end
    if (n >= 20) chk("send_accept", {axil.awvalid, axil.wvalid}, 0);
    axil.awvalid = 1'b0;
    axil.wvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] ea, ed;
    int gap, n;
    axil.awaddr = '0; axil.awprot = 3'd0; axil.awuser = '0; axil.awvalid = 1'b0;
    axil.wdata = '0; axil.wstrb = '0; axil.wuser = '0; axil.wvalid = 1'b0;
    axil.bready = 1'b0;

    // reset state
    step(); step();
    chk("rst_awready", axil.awready, 0);
    chk("rst_wready", axil.wready, 0);
    chk("rst_bvalid", axil.bvalid, 0);
    chk("rst_en", reg_wr_en, 0);
    chk("rst_addr", reg_wr_addr, 0);
    chk("rst_data", reg_wr_data, 0);
    rst_n = 1'b1;
    chk("rel_awready_pre", axil.awready, 0);
    step();
    chk("rel_awready", axil.awready, 1);
    chk("rel_wready", axil.wready, 1);

    // AW+W same cycle, zero-wait target
    send(32'h0000_0013, 32'hDEAD_BEEF, 4'hF);
    chk("t1_en", reg_wr_en, 1);
    chk("t1_addr", reg_wr_addr, 32'h10);
    chk("t1_data", reg_wr_data, 32'hDEAD_BEEF);
    chk("t1_strb", reg_wr_strb, 4'hF);
    chk("t1_awready_busy", axil.awready, 0);
    step();
    chk("t1_en_drop", reg_wr_en, 0);
    chk("t1_bvalid", axil.bvalid, 1);
    chk("t1_bresp", axil.bresp, 2'b00);
    axil.bready = 1'b1;
    step();
    chk("t1_bvalid_drop", axil.bvalid, 0);
    chk("t1_awready_back", axil.awready, 1);
    chk("t1_wready_back", axil.wready, 1);
    axil.bready = 1'b0;

    // W three cycles ahead of AW
    axil.wdata = 32'h1122_3344; axil.wstrb = 4'h5; axil.wvalid = 1'b1;
    step();
    axil.wvalid = 1'b0;
    chk("t2_wready_held", axil.wready, 0);
    chk("t2_awready_open", axil.awready, 1);
    for (int k = 0; k < 2; k++) begin
      chk("t2_no_en", reg_wr_en, 0);
      step();
    end
    chk("t2_no_en", reg_wr_en, 0);
    axil.awaddr = 32'h0000_0026; axil.awvalid = 1'b1;
    step();
    axil.awvalid = 1'b0;
    chk("t2_en", reg_wr_en, 1);
    chk("t2_addr", reg_wr_addr, 32'h24);
    chk("t2_data", reg_wr_data, 32'h1122_3344);
    chk("t2_strb", reg_wr_strb, 4'h5);
    step();
    chk("t2_en_drop", reg_wr_en, 0);
    chk("t2_bvalid", axil.bvalid, 1);
    axil.bready = 1'b1;
    step();
    axil.bready = 1'b0;
    chk("t2_bvalid_drop", axil.bvalid, 0);

    // stalled target, ack on the third issue cycle, bready held off
    reg_wr_wait = 1'b1;
    send(32'h0000_0040, 32'hCAFE_0001, 4'hF);
    chk("t3_en_c1", reg_wr_en, 1);
    step();
    chk("t3_en_c2", reg_wr_en, 1);
    step();
    chk("t3_en_c3", reg_wr_en, 1);
    reg_wr_ack = 1'b1;
    step();
    reg_wr_ack = 1'b0;
    reg_wr_wait = 1'b0;
    chk("t3_en_drop", reg_wr_en, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t3_bvalid_hold", axil.bvalid, 1);
      chk("t3_bresp", axil.bresp, 2'b00);
      if (k < 3) step();
    end
    axil.bready = 1'b1;
    step();
    axil.bready = 1'b0;
    chk("t3_bvalid_drop", axil.bvalid, 0);
    step();
    chk("t3_no_second_b", axil.bvalid, 0);

    // wait held high
    reg_wr_wait = 1'b1;
    send(32'h0000_0080, 32'h0BAD_F00D, 4'h3);
`ifdef TAXI_AXIL_REG_IF_WR_TIMEOUT_EN
    for (int k = 0; k < 5; k++) begin
      chk("t4_en_stall", reg_wr_en, 1);
      step();
    end
    chk("t4_en_timeout", reg_wr_en, 0);
    chk("t4_bvalid", axil.bvalid, 1);
    chk("t4_bresp_slverr", axil.bresp, 2'b10);
    reg_wr_wait = 1'b0;
`else
    for (int k = 0; k < 9; k++) begin
      chk("t4_en_stall", reg_wr_en, 1);
      step();
    end
    chk("t4_en_stall", reg_wr_en, 1);
    chk("t4_no_bvalid", axil.bvalid, 0);
    reg_wr_wait = 1'b0;
    step();
    chk("t4_en_drop", reg_wr_en, 0);
    chk("t4_bvalid", axil.bvalid, 1);
    chk("t4_bresp_okay", axil.bresp, 2'b00);
`endif
    axil.bready = 1'b1;
    step();
    axil.bready = 1'b0;
    chk("t4_bvalid_drop", axil.bvalid, 0);

    // reset in the middle of ISSUE
    reg_wr_wait = 1'b1;
    send(32'h0000_00C0, 32'h5555_AAAA, 4'hF);
    chk("t5_en", reg_wr_en, 1);
    step();
    axil.bready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_en_async", reg_wr_en, 0);
    chk("t5_bvalid_async", axil.bvalid, 0);
    chk("t5_awready_async", axil.awready, 0);
    reg_wr_wait = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t5_awready_rel", axil.awready, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_en", reg_wr_en, 0);
      chk("t5_no_bvalid", axil.bvalid, 0);
      step();
    end
    axil.bready = 1'b0;

    // 20 writes, random bready gaps
    q_addr.delete(); q_data.delete(); q_strb.delete(); q_resp.delete();
    for (int i = 0; i < 20; i++) begin
      send(32'h100 + 32'(i) * 4 + 32'(i % 4), 32'hA500_0000 ^ (32'(i) * 32'h0101_0101), 4'hF);
      n = 0;
      while (!axil.bvalid && n < 10) begin
        step();
        n++;
      end
      if (n >= 10) chk("t6_bvalid_wait", axil.bvalid, 1);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      axil.bready = 1'b1;
      step();
      axil.bready = 1'b0;
    end
    step();
    chk("t6_strobes", q_addr.size(), 20);
    chk("t6_resps", q_resp.size(), 20);
    for (int i = 0; i < 20 && i < q_addr.size(); i++) begin
      ea = 32'h100 + 32'(i) * 4;
      ed = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
      chk($sformatf("t6_addr%0d", i), q_addr[i], ea);
      chk($sformatf("t6_data%0d", i), q_data[i], ed);
      chk($sformatf("t6_strb%0d", i), q_strb[i], 4'hF);
    end
    for (int i = 0; i < 20 && i < q_resp.size(); i++)
      chk($sformatf("t6_resp%0d", i), q_resp[i], 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/taxi_axil_reg_if_wr.md
# taxi_axil_reg_if_wr

AXI4-lite write-channel endpoint that terminates the write side of an AXI4-lite bus and converts each transaction into a single-cycle-issue register write strobe with optional wait/ack stretching. Sits downstream of the AXI4-lite write tie/interconnect stages, consuming the `wr_mst` side they produce, and drives a flat register bank or CSR decoder.

## Interface
- TIMEOUT, 4: cycles a stalled register write waits before forced completion; must be ≥1.
- DATA_W, ADDR_W, STRB_W: taken from `s_axil_wr`, not module parameters.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axil_wr  `taxi_axil_if.wr_slv`  AXI4-lite write slave.
- reg_wr_addr  out  ADDR_W  word address; low $clog2(STRB_W) bits forced to 0.
- reg_wr_data  out  DATA_W  write data.
- reg_wr_strb  out  STRB_W  byte strobes.
- reg_wr_en  out  1  write request, held while pending.
- reg_wr_wait  in  1  target stall; sampled only while reg_wr_en=1.
- reg_wr_ack  in  1  target completion; sampled only while reg_wr_en=1.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: awready=1 until AW captured, wready=1 until W captured; AW and W may arrive in either order or the same cycle. Each holds its own capture flag. Both captured -> ISSUE.
- ISSUE: reg_wr_en=1 with registered addr/data/strb. Completion when reg_wr_ack=1 OR reg_wr_wait=0 -> RESP, bresp=OKAY (2'b00).
- RESP: bvalid=1, bresp stable until bready=1; handshake -> IDLE with capture flags cleared.
- awprot, awuser, wuser ignored; buser driven 0.
- Ack and timeout expiry in same cycle: ack wins, OKAY.
- Ack with reg_wr_wait=1: still completes.

## Timing
- Reset (async assert): awready=0, wready=0, bvalid=0, bresp=0, reg_wr_en=0, reg_wr_addr/data/strb=0, FSM=IDLE, counter=0. awready/wready rise on the first clk edge after rst_n deasserts.
- Reset mid-transaction: pending write dropped; no reg_wr_en or bvalid after release.
- All outputs registered; no combinational path from any input to any output.
- AW and W handshaked on cycle T -> reg_wr_en=1 at T+1.
- Zero-wait target (wait=0 at T+1) -> reg_wr_en=0, bvalid=1 at T+2.
- bready=1 at T+2 -> bvalid=0, awready=wready=1 at T+3. Peak throughput: one write per 3 cycles.
- AW at T, W at T+k -> reg_wr_en at T+k+1. awready=0 from T+1 while W is outstanding.
- reg_wr_en remains 1 for exactly the cycles spent in ISSUE, then drops on the cycle bvalid rises.

## Configuration
- `TAXI_AXIL_REG_IF_WR_TIMEOUT_EN` defined:
  - counter, $clog2(TIMEOUT+1) bits, increments each ISSUE cycle with wait=1 and ack=0.
  - On the cycle it reaches TIMEOUT: reg_wr_en drops, -> RESP with bresp=SLVERR (2'b10).
  - Counter clears on entering ISSUE.
- Undefined: no counter logic; ISSUE waits indefinitely for ack or wait=0; bresp always OKAY.

## Structure
- Shared package `taxi_axil_pkg`: AXI response encodings (OKAY, SLVERR) and the FSM state enum type.
- No sub-module; single flat module. A read-side sibling `taxi_axil_reg_if_rd` shares the package.

## Test plan
- AW+W same cycle, addr 0x0000_0013, data 0xDEADBEEF, strb 0xF, wait=0 -> reg_wr_en 1 cycle at T+1 with addr 0x10, data 0xDEADBEEF, strb 0xF; bvalid at T+2, bresp=0.
- W 3 cycles before AW, strb 0x5 -> no reg_wr_en until AW accepted; then one strobe with strb 0x5.
- wait=1, ack after 2 cycles -> reg_wr_en high 3 cycles; bresp=OKAY; bvalid held 4 cycles under bready=0, then single handshake.
- TIMEOUT=4 with macro, wait held 1 -> reg_wr_en high 5 cycles, bresp=2'b10. Without macro -> reg_wr_en stays high until wait drops.
- rst_n pulsed low during ISSUE -> reg_wr_en and bvalid drop immediately; awready=1 one cycle after release; no stale response.
- 20 back-to-back writes with random bready gaps -> 20 strobes, 20 responses, in order, data matching.
